serial_alu_ctrl: RTL and testbench
==================================

SERIAL_ALU_CTRL -- requirements
Module: serial_alu_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port op  input  3  opcode: 0 ADD, 1 SUB, 2 XOR, 3 SLT, 4 AND, 5 NAND, 6 NOR, 7 OR.
REQ-007 SHALL have ports a, b  input  WIDTH  operands, two's complement.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port result  output  WIDTH  operation result.
REQ-011 SHALL have ports carryout, overflow, zero  output  1 each  status flags.

Function
REQ-012 SHALL compute every operation bit-serially through one 1-bit ALU slice, LSB first, one bit per clock.
REQ-013 SHALL drive the slice per op: ADD sel=0,invta=0,invtb=0,cin0=0; SUB sel=1,invtb=1,cin0=1; XOR sel=2; SLT sel=3,invtb=1,cin0=1; AND sel=4,invta=invtb=1; NAND sel=5; NOR sel=6; OR sel=7,invta=invtb=1.
REQ-014 SHALL hold the carry in a flop: bit 0 uses cin0, bit i uses slice cout from bit i-1.
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE.
REQ-016 IDLE->RUN when in_valid; latch op, a, b; clear bit counter and result register.
REQ-017 RUN: each cycle process bit index cnt, shift slice result into result register MSB-side; RUN->DONE after cnt=WIDTH-1.
REQ-018 DONE: out_valid=1, result and flags stable; DONE->IDLE when out_ready.
REQ-019 Latency SHALL be exactly WIDTH+1 cycles from accepting edge to first out_valid cycle; throughput one op per WIDTH+2 cycles with out_ready held high.
REQ-020 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB for ADD/SUB/SLT, else 0.
REQ-021 carryout SHALL equal final MSB cout for ADD/SUB, else 0.
REQ-022 SLT result SHALL be {WIDTH-1 zeros, (MSB of a-b) XOR overflow}; carryout=0.
REQ-023 zero SHALL equal 1 when final result is all zeros.
REQ-024 in_valid while not IDLE SHALL be ignored; latched operands SHALL not change during RUN/DONE.
REQ-025 out_ready outside DONE SHALL have no effect; DONE SHALL hold indefinitely while out_ready=0.

Reset
REQ-026 reset SHALL force IDLE, counter=0, carry=0, result=0, flags=0, out_valid=0, in_ready=1 on the next edge.
REQ-027 reset in RUN or DONE SHALL abort the operation with no out_valid pulse; reset dominates in_valid.

Configuration
REQ-028 Macro SERIAL_ALU_FLAGS_EN SHALL gate flag logic.
REQ-029 Defined: carryout, overflow, zero per REQ-020..023. Undefined: those three ports tied 0, flag flops removed; SLT still computes overflow internally for its result.

Structure
REQ-030 Shared package serial_alu_pkg SHALL hold opcode constants, slice select constants, FSM state encodings.
REQ-031 Sole sub-module SHALL be the team's existing one-bit ALU slice (aluslice); FSM, counter, shift registers, flags in serial_alu_ctrl.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01 -> result=0x80, overflow=1, carryout=0, zero=0, out_valid 9 cycles after accept edge.
REQ-033 SUB a=0x05 b=0x07 -> 0xFE, carryout=0, overflow=0; SUB 0x07-0x07 -> 0x00, zero=1, carryout=1.
REQ-034 SLT a=0xFD b=0x02 -> 0x01; SLT a=0x80 b=0x7F -> 0x01 (overflow path); SLT a=0x02 b=0xFD -> 0x00.
REQ-035 AND 0xF0,0x3C -> 0x30; OR -> 0xFC; NOR -> 0x03; NAND -> 0xCF; XOR -> 0xCC.
REQ-036 out_ready=0 for 5 cycles in DONE -> result held, in_valid pulses ignored, in_ready=0; then out_ready=1 -> IDLE next edge.
REQ-037 reset asserted at cnt=4 of RUN -> next cycle IDLE, all outputs 0, in_ready=1, no out_valid.

Source files
------------

// File: rtl/serial_alu_pkg.sv
// -----------------------------------------------------------------------------
// serial_alu_pkg
// Shared definitions for the bit-serial ALU controller and its one-bit slice:
//   - opcode constants (op port encoding)
//   - slice select constants (aluslice sel encoding)
//   - controller FSM state encoding
//   - decode_op(): maps an opcode to the slice control word
// -----------------------------------------------------------------------------
package serial_alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_SLT  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_NAND = 3'd5;
    localparam logic [2:0] OP_NOR  = 3'd6;
    localparam logic [2:0] OP_OR   = 3'd7;

    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_XOR  = 3'd2;
    localparam logic [2:0] SEL_SLT  = 3'd3;
    localparam logic [2:0] SEL_AND  = 3'd4;
    localparam logic [2:0] SEL_NAND = 3'd5;
    localparam logic [2:0] SEL_NOR  = 3'd6;
    localparam logic [2:0] SEL_OR   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [2:0] sel;
        logic       invta;
        logic       invtb;
        logic       cin0;
    } slice_ctl_t;

    // AND and OR reuse the slice's NOR/NAND gates on inverted operands
    // (De Morgan), so they set both invert controls.
    function automatic slice_ctl_t decode_op(input logic [2:0] opc);
        slice_ctl_t c;
        c.sel   = SEL_ADD;
        c.invta = 1'b0;
        c.invtb = 1'b0;
        c.cin0  = 1'b0;
        case (opc)
            OP_ADD:  c.sel = SEL_ADD;
            OP_SUB:  begin c.sel = SEL_SUB; c.invtb = 1'b1; c.cin0 = 1'b1; end
            OP_XOR:  c.sel = SEL_XOR;
            OP_SLT:  begin c.sel = SEL_SLT; c.invtb = 1'b1; c.cin0 = 1'b1; end
            OP_AND:  begin c.sel = SEL_AND; c.invta = 1'b1; c.invtb = 1'b1; end
            OP_NAND: c.sel = SEL_NAND;
            OP_NOR:  c.sel = SEL_NOR;
            OP_OR:   begin c.sel = SEL_OR; c.invta = 1'b1; c.invtb = 1'b1; end
            default: c.sel = SEL_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aluslice.sv
// -----------------------------------------------------------------------------
// aluslice
// One-bit ALU slice. Operands are optionally inverted, then a full adder and
// NAND/NOR/XOR gates produce the candidate results; sel picks one.
// Ports:
//   a, b         operand bits
//   cin          carry in
//   invta, invtb invert a / b before use
//   sel[2:0]     result select (SEL_* in serial_alu_pkg)
//   res          selected result bit
//   cout         full-adder carry out (always the adder's carry)
// -----------------------------------------------------------------------------
module aluslice
    import serial_alu_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic       invta,
    input  logic       invtb,
    input  logic [2:0] sel,
    output logic       res,
    output logic       cout
);

    logic ai;
    logic bi;
    logic sum;

    assign ai   = a ^ invta;
    assign bi   = b ^ invtb;
    assign sum  = ai ^ bi ^ cin;
    assign cout = (ai & bi) | (cin & (ai ^ bi));

    always_comb begin
        res = sum;
        case (sel)
            SEL_XOR:           res = ai ^ bi;
            SEL_AND, SEL_NOR:  res = ~(ai | bi);
            SEL_NAND, SEL_OR:  res = ~(ai & bi);
            default:           res = sum;
        endcase
    end

endmodule

// File: rtl/serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// serial_alu_ctrl
// Bit-serial ALU: latches op/a/b on acceptance, then runs one bit per clock,
// LSB first, through a single aluslice. The result is shifted in from the
// MSB side so it is aligned after WIDTH bits. Result stays stable in DONE
// until out_ready.
// Parameters:
//   WIDTH       operand/result width, 2..64
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   in_valid / in_ready     request handshake (in_ready only in IDLE)
//   op[2:0], a, b           opcode and two's complement operands
//   out_valid / out_ready   result handshake (out_valid only in DONE)
//   result                  operation result
//   carryout, overflow, zero status flags
// Configuration:
//   SERIAL_ALU_FLAGS_EN     when defined, flag flops are built; otherwise the
//                           three flag outputs are tied to 0.
// -----------------------------------------------------------------------------
module serial_alu_ctrl
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 32
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CW-1:0]    cnt;
    logic             carry_q;

    slice_ctl_t       ctl;
    logic             s_cin;
    logic             s_res;
    logic             s_cout;
    logic             last;
    logic             ovf_int;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] res_final;

    assign ctl   = decode_op(op_q);
    assign last  = (cnt == LAST);
    assign s_cin = (cnt == '0) ? ctl.cin0 : carry_q;

    aluslice u_slice (
        .a     (a_q[cnt]),
        .b     (b_q[cnt]),
        .cin   (s_cin),
        .invta (ctl.invta),
        .invtb (ctl.invtb),
        .sel   (ctl.sel),
        .res   (s_res),
        .cout  (s_cout)
    );

    // Only meaningful on the MSB cycle: carry into MSB vs carry out of MSB.
    assign ovf_int   = s_cin ^ s_cout;
    assign res_shift = {s_res, res_q[WIDTH-1:1]};
    assign res_final = (op_q == OP_SLT) ? WIDTH'(s_res ^ ovf_int) : res_shift;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last)      state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = ST_IDLE;
            default:                state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    // Operand latch, bit counter, carry flop and result shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q    <= op;
                        a_q     <= a;
                        b_q     <= b;
                        cnt     <= '0;
                        carry_q <= 1'b0;
                        res_q   <= '0;
                    end
                end
                ST_RUN: begin
                    carry_q <= s_cout;
                    res_q   <= last ? res_final : res_shift;
                    cnt     <= last ? '0 : cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = res_q;

`ifdef SERIAL_ALU_FLAGS_EN
    logic cout_q;
    logic ovf_q;
    logic zero_q;
    logic is_addsub;
    logic is_arith;

    assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_arith  = is_addsub || (op_q == OP_SLT);

    // Flags are captured on the MSB cycle, alongside the final result.
    always_ff @(posedge clk) begin
        if (reset) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == ST_IDLE && in_valid) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (state == ST_RUN && last) begin
            cout_q <= is_addsub & s_cout;
            ovf_q  <= is_arith & ovf_int;
            zero_q <= (res_final == '0);
        end
    end

    assign carryout = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;
`else
    assign carryout = 1'b0;
    assign overflow = 1'b0;
    assign zero     = 1'b0;
`endif

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_alu_ctrl
// Directed bench for serial_alu_ctrl at WIDTH=8. Expected values are
// hand-computed constants; flag expectations collapse to 0 when the
// SERIAL_ALU_FLAGS_EN build option is absent.
// -----------------------------------------------------------------------------
module tb_serial_alu_ctrl;

    localparam int W = 8;
`ifdef SERIAL_ALU_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    serial_alu_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction with out_ready held high. The accept edge is the
    // first step; DONE must appear exactly W edges later (cycle W+1).
    task automatic run_op(input string tag, input logic [2:0] t_op,
                          input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic [W-1:0] e_res, input logic e_c,
                          input logic e_v, input logic e_z);
        op        = t_op;
        a         = t_a;
        b         = t_b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, "_in_ready_idle"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        // Scramble inputs: the latched operands must be used.
        op = ~t_op;
        a  = ~t_a;
        b  = ~t_b;
        chk({tag, "_in_ready_run"}, in_ready, 0);
        repeat (W - 1) step();
        chk({tag, "_out_valid_early"}, out_valid, 0);
        step();
        chk({tag, "_out_valid"}, out_valid, 1);
        chk({tag, "_result"}, result, e_res);
        chk({tag, "_carryout"}, carryout, FLAGS ? e_c : 1'b0);
        chk({tag, "_overflow"}, overflow, FLAGS ? e_v : 1'b0);
        chk({tag, "_zero"}, zero, FLAGS ? e_z : 1'b0);
        step();
        chk({tag, "_back_idle"}, in_ready, 1);
        chk({tag, "_out_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        int pulses;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 3'd0;
        a         = '0;
        b         = '0;
        step();
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {carryout, overflow, zero}, 0);
        reset = 1'b0;
        step();

        //      tag          op    a      b      res    c     v     z
        run_op("add_ovf",   3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_neg",   3'd1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
        run_op("sub_zero",  3'd1, 8'h07, 8'h07, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_neg",   3'd3, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("slt_ovf",   3'd3, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op("slt_false", 3'd3, 8'h02, 8'hFD, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("and",       3'd4, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
        run_op("or",        3'd7, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
        run_op("nor",       3'd6, 8'hF0, 8'h3C, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op("nand",      3'd5, 8'hF0, 8'h3C, 8'hCF, 1'b0, 1'b0, 1'b0);
        run_op("xor",       3'd2, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b0, 1'b0);
        run_op("add_wrap",  3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);

        // DONE holds while out_ready is low; in_valid pulses are ignored.
        op        = 3'd0;
        a         = 8'h10;
        b         = 8'h20;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (W) step();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            a        = 8'hAA;
            step();
            chk("hold_out_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, 8'h30);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("hold_release_idle", in_ready, 1);
        chk("hold_release_ov", out_valid, 0);

        // Reset at cnt=4 of RUN aborts the op; reset beats in_valid.
        op       = 3'd0;
        a        = 8'h7F;
        b        = 8'h01;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (4) step();
        reset    = 1'b1;
        in_valid = 1'b1;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_flags", {carryout, overflow, zero}, 0);
        pulses = 0;
        for (int i = 0; i < W + 3; i++) begin
            step();
            if (out_valid) pulses++;
        end
        chk("abort_no_out_valid", pulses, 0);
        chk("abort_still_idle", in_ready, 1);

        run_op("post_abort", 3'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
